// File: rtl/imem_fetch_unit_pkg.sv
// Shared processor package for the instruction fetch path:
// the fetch FSM state encoding and the default NOP instruction word.
package imem_fetch_unit_pkg;

    // The fetch unit has two modes.
    // In CLEAR it wipes the program memory.
    // In RUN it serves fetches and program loads.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_e;

    // ARM "MOV r0, r0". It fills cleared memory and is returned for invalid fetches.
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hE1A00000;

endpackage

// File: rtl/imem_fetch_unit_array.sv
// Single-write, single-read synchronous RAM with a registered read port.
// A read and a write to the same address in one cycle return the new data.
module imem_array #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 16,
    parameter int                ADDR_W     = 4,
    parameter logic [DATA_W-1:0] RESET_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // The storage array has no reset; the owner must initialise it explicitly.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read that bypasses a same-cycle write (write-first).
    // The read register holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= RESET_WORD;
        end else if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory fetch unit.
// After reset it clears the program RAM to NOP, then serves 1-cycle-latency
// fetches with consumer back-pressure and accepts program loads.
module imem_fetch_unit
    import imem_fetch_unit_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              stall,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              addr_fault,
    output logic              busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic              addr_fault_q, addr_fault_d;

    logic              loadInRange;
    logic              fetchInRange;
    logic              fetchAccept;
    logic              memWe;
    logic [ADDR_W-1:0] memWaddr;
    logic [DATA_W-1:0] memWdata;
    logic              memRe;
    logic [DATA_W-1:0] memRdata;

    assign loadInRange  = (32'(load_addr)  < DEPTH);
    assign fetchInRange = (32'(fetch_addr) < DEPTH);
    assign fetchAccept  = fetch_req && fetch_ready;

    // State and clear-counter registers; reset restarts the clear sweep from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The clear sweep stops on the last location and hands over to RUN without wrapping.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    // FSM outputs: busy while clearing; in RUN, fetch_ready drops only when a held word is stalled.
    always_comb begin
        busy        = (state_q == ST_CLEAR);
        fetch_ready = (state_q == ST_RUN) && !(instr_valid_q && stall);
    end

    // RAM port steering.
    // The clear sweep owns the write port in CLEAR.
    // Out-of-range loads and fetches never reach the array.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = load_addr;
        memWdata = load_data;
        memRe    = fetchAccept && fetchInRange;
        if (state_q == ST_CLEAR) begin
            memWe    = 1'b1;
            memWaddr = clr_cnt_q;
            memWdata = NOP_WORD;
        end else begin
            memWe    = load_en && loadInRange;
        end
    end

    // Output register control.
    // An accepted fetch loads it.
    // A stalled valid word is held.
    // Otherwise valid drops while the address and data stay put.
    always_comb begin
        instr_valid_d = instr_valid_q;
        instr_addr_d  = instr_addr_q;
        addr_fault_d  = addr_fault_q;
        if (fetchAccept) begin
            instr_valid_d = 1'b1;
            instr_addr_d  = fetch_addr;
            addr_fault_d  = !fetchInRange;
        end else if (!(instr_valid_q && stall)) begin
            instr_valid_d = 1'b0;
        end
    end

    // Output register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_q <= 1'b0;
            instr_addr_q  <= '0;
            addr_fault_q  <= 1'b0;
        end else begin
            instr_valid_q <= instr_valid_d;
            instr_addr_q  <= instr_addr_d;
            addr_fault_q  <= addr_fault_d;
        end
    end

    imem_array #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .RESET_WORD (NOP_WORD)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (memWe),
        .waddr (memWaddr),
        .wdata (memWdata),
        .re    (memRe),
        .raddr (fetch_addr),
        .rdata (memRdata)
    );

    assign instr_valid = instr_valid_q;
    assign instr_addr  = instr_addr_q;
    assign addr_fault  = addr_fault_q;
    assign instr_out   = addr_fault_q ? NOP_WORD : memRdata;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed testbench for imem_fetch_unit.
// dutA uses the default DEPTH=16.
// dutB uses DEPTH=12 to exercise fetches and loads beyond the array.
// Both instances are driven by the same stimulus.
module tb_imem_fetch_unit;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        fetch_req;
    logic [3:0]  fetch_addr;
    logic        stall;

    logic        readyA, validA, faultA, busyA;
    logic [31:0] outA;
    logic [3:0]  addrA;
    logic        readyB, validB, faultB, busyB;
    logic [31:0] outB;
    logic [3:0]  addrB;

    int checks;
    int errors;
    logic [31:0] expB [12];

    imem_fetch_unit dutA (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (readyA),
        .stall       (stall),
        .instr_valid (validA),
        .instr_out   (outA),
        .instr_addr  (addrA),
        .addr_fault  (faultA),
        .busy        (busyA)
    );

    imem_fetch_unit #(.DEPTH(12), .ADDR_W(4)) dutB (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (readyB),
        .stall       (stall),
        .instr_valid (validB),
        .instr_out   (outB),
        .instr_addr  (addrB),
        .addr_fault  (faultB),
        .busy        (busyB)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, then waits for the following falling edge.
    task automatic applyStimulus(input logic ld, input logic [3:0] la, input logic [31:0] ldat,
                                 input logic fr, input logic [3:0] fa, input logic st);
        load_en    = ld;
        load_addr  = la;
        load_data  = ldat;
        fetch_req  = fr;
        fetch_addr = fa;
        stall      = st;
        @(negedge clk);
    endtask

    // Sets the stimulus inputs to their idle values.
    task automatic idleInputs();
        load_en = 0; load_addr = 0; load_data = 0;
        fetch_req = 0; fetch_addr = 0; stall = 0;
    endtask

    // Main directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        idleInputs();
        for (int i = 0; i < 12; i++) expB[i] = NOP;

        // Assert reset and check the reset values of dutA.
        rst_n = 0;
        #12;
        checkOutput("rst_busy", {31'd0, busyA}, 32'd1);
        checkOutput("rst_ready", {31'd0, readyA}, 32'd0);
        checkOutput("rst_valid", {31'd0, validA}, 32'd0);
        checkOutput("rst_out", outA, NOP);
        checkOutput("rst_addr", {28'd0, addrA}, 32'd0);
        checkOutput("rst_fault", {31'd0, faultA}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Clear sweep: busy lasts exactly DEPTH cycles for each instance.
        for (int i = 0; i < 18; i++) begin
            checkOutput($sformatf("clr_busyA_%0d", i), {31'd0, busyA}, {31'd0, (i < 16)});
            checkOutput($sformatf("clr_readyA_%0d", i), {31'd0, readyA}, {31'd0, (i >= 16)});
            checkOutput($sformatf("clr_busyB_%0d", i), {31'd0, busyB}, {31'd0, (i < 12)});
            @(negedge clk);
        end

        // A fetch from cleared memory returns NOP.
        applyStimulus(0, 0, 0, 1, 4'd5, 0);
        checkOutput("f5_valid", {31'd0, validA}, 32'd1);
        checkOutput("f5_out", outA, NOP);
        checkOutput("f5_addr", {28'd0, addrA}, 32'd5);

        // Load address 3, then fetch it.
        applyStimulus(1, 4'd3, 32'hE3A01016, 0, 0, 0);
        expB[3] = 32'hE3A01016;
        applyStimulus(0, 0, 0, 1, 4'd3, 0);
        checkOutput("f3_valid", {31'd0, validA}, 32'd1);
        checkOutput("f3_out", outA, 32'hE3A01016);
        checkOutput("f3_addr", {28'd0, addrA}, 32'd3);

        // Idle cycle: valid drops, while data and address are kept.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("idle_valid", {31'd0, validA}, 32'd0);
        checkOutput("idle_out", outA, 32'hE3A01016);
        checkOutput("idle_addr", {28'd0, addrA}, 32'd3);

        // Same-cycle load and fetch of address 7 returns the new data.
        applyStimulus(1, 4'd7, 32'h8A000004, 1, 4'd7, 0);
        expB[7] = 32'h8A000004;
        checkOutput("wf7_outA", outA, 32'h8A000004);
        checkOutput("wf7_outB", outB, 32'h8A000004);

        // Preload addresses 2 and 4 for the stall test.
        applyStimulus(1, 4'd2, 32'h12345678, 0, 0, 0);
        expB[2] = 32'h12345678;
        applyStimulus(1, 4'd4, 32'hCAFEF00D, 0, 0, 0);
        expB[4] = 32'hCAFEF00D;

        // Fetch 2 while stall is high.
        // It is accepted because nothing valid is being held.
        applyStimulus(0, 0, 0, 1, 4'd2, 1);
        checkOutput("st_valid", {31'd0, validA}, 32'd1);
        checkOutput("st_out", outA, 32'h12345678);

        // Hold stall for 3 cycles with fetch 4 pending.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 4'd4, 1);
            checkOutput($sformatf("hold_ready_%0d", i), {31'd0, readyA}, 32'd0);
            checkOutput($sformatf("hold_valid_%0d", i), {31'd0, validA}, 32'd1);
            checkOutput($sformatf("hold_out_%0d", i), outA, 32'h12345678);
            checkOutput($sformatf("hold_addr_%0d", i), {28'd0, addrA}, 32'd2);
        end

        // Release stall: fetch 4 is accepted now and appears on the next cycle.
        stall = 0;
        #1;
        checkOutput("rel_ready", {31'd0, readyA}, 32'd1);
        @(negedge clk);
        checkOutput("rel_valid", {31'd0, validA}, 32'd1);
        checkOutput("rel_out", outA, 32'hCAFEF00D);
        checkOutput("rel_addr", {28'd0, addrA}, 32'd4);

        // Fetch 14: within range for dutA, a fault for dutB.
        applyStimulus(0, 0, 0, 1, 4'd14, 0);
        checkOutput("f14_outA", outA, NOP);
        checkOutput("f14_faultA", {31'd0, faultA}, 32'd0);
        checkOutput("f14_outB", outB, NOP);
        checkOutput("f14_faultB", {31'd0, faultB}, 32'd1);
        checkOutput("f14_addrB", {28'd0, addrB}, 32'd14);

        // Load address 14.
        // dutA stores it; dutB ignores it.
        applyStimulus(1, 4'd14, 32'hDEADBEEF, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd14, 0);
        checkOutput("l14_outA", outA, 32'hDEADBEEF);
        checkOutput("l14_outB", outB, NOP);
        checkOutput("l14_faultB", {31'd0, faultB}, 32'd1);

        // dutB locations 0..11 are untouched by the ignored load.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 0, 1, 4'(i), 0);
            checkOutput($sformatf("scanB_out_%0d", i), outB, expB[i]);
            checkOutput($sformatf("scanB_fault_%0d", i), {31'd0, faultB}, 32'd0);
        end
        idleInputs();

        // Reset during RUN takes effect immediately.
        rst_n = 0;
        #1;
        checkOutput("runrst_valid", {31'd0, validA}, 32'd0);
        checkOutput("runrst_out", outA, NOP);
        checkOutput("runrst_addr", {28'd0, addrA}, 32'd0);
        checkOutput("runrst_busy", {31'd0, busyA}, 32'd1);
        @(negedge clk);
        rst_n = 1;

        // Reset again on cycle 5 of CLEAR.
        for (int i = 0; i < 5; i++) @(negedge clk);
        checkOutput("midclr_busy_pre", {31'd0, busyA}, 32'd1);
        rst_n = 0;
        #1;
        checkOutput("midclr_busy", {31'd0, busyA}, 32'd1);
        checkOutput("midclr_ready", {31'd0, readyA}, 32'd0);
        checkOutput("midclr_valid", {31'd0, validA}, 32'd0);
        checkOutput("midclr_out", outA, NOP);
        @(negedge clk);
        rst_n = 1;

        // The restarted sweep lasts a full DEPTH cycles.
        for (int i = 0; i < 18; i++) begin
            checkOutput($sformatf("reclr_busyA_%0d", i), {31'd0, busyA}, {31'd0, (i < 16)});
            @(negedge clk);
        end

        // Memory is re-cleared: previously loaded words read back as NOP.
        applyStimulus(0, 0, 0, 1, 4'd3, 0);
        checkOutput("reclr_f3", outA, NOP);
        applyStimulus(0, 0, 0, 1, 4'd14, 0);
        checkOutput("reclr_f14", outA, NOP);
        idleInputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16, number of words; any value 2..1024.
REQ-003 SHALL have parameter ADDR_W, default 4, address width, with 2**ADDR_W >= DEPTH.
REQ-004 SHALL have parameter NOP_WORD, default 32'hE1A00000, word returned for cleared or invalid locations.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port load_en, input, 1, program-write strobe.
REQ-008 SHALL have port load_addr, input, ADDR_W, program-write address.
REQ-009 SHALL have port load_data, input, DATA_W, program-write data.
REQ-010 SHALL have port fetch_req, input, 1, fetch request valid.
REQ-011 SHALL have port fetch_addr, input, ADDR_W, word address, i.e. the PC.
REQ-012 SHALL have port fetch_ready, output, 1, fetch request accepted this cycle.
REQ-013 SHALL have port stall, input, 1, consumer not ready; holds the output register.
REQ-014 SHALL have port instr_valid, output, 1, instr_out is valid.
REQ-015 SHALL have port instr_out, output, DATA_W, fetched instruction.
REQ-016 SHALL have port instr_addr, output, ADDR_W, address of instr_out.
REQ-017 SHALL have port addr_fault, output, 1, instr_out came from an address >= DEPTH.
REQ-018 SHALL have port busy, output, 1, high while in CLEAR.

Function
REQ-019 SHALL implement the FSM states CLEAR and RUN.
REQ-020 In CLEAR, SHALL write NOP_WORD to one location per cycle using a clear counter from 0 to DEPTH-1, then enter RUN on the following cycle; clearing takes exactly DEPTH cycles.
REQ-021 In CLEAR, SHALL hold fetch_ready=0 and busy=1, and SHALL ignore load_en.
REQ-022 In RUN, SHALL set fetch_ready = !(instr_valid && stall); a fetch is accepted when fetch_req && fetch_ready.
REQ-023 SHALL present an accepted fetch on the next cycle, with 1-cycle latency: instr_valid=1, instr_out=mem[fetch_addr], and instr_addr=fetch_addr.
REQ-024 With no fetch accepted and stall=0, SHALL drive instr_valid=0 next cycle and leave instr_out and instr_addr unchanged.
REQ-025 While stall=1 and instr_valid=1, SHALL hold instr_valid, instr_out, instr_addr and addr_fault stable.
REQ-026 In RUN, SHALL perform load_en writes regardless of fetch or stall, and SHALL ignore writes to addresses >= DEPTH.
REQ-027 On a load and an accepted fetch to the same address in the same cycle, SHALL return load_data (write-first).
REQ-028 SHALL return NOP_WORD with addr_fault=1 for a fetch to an address >= DEPTH, and SHALL leave memory untouched.
REQ-029 SHALL reach DEPTH-1 on the clear counter without wrap-around; the counter SHALL NOT be reused in RUN.

Reset
REQ-030 On rst_n=0, SHALL immediately set state=CLEAR, clear counter=0, instr_valid=0, instr_out=NOP_WORD, instr_addr=0, addr_fault=0, fetch_ready=0 and busy=1.
REQ-031 SHALL make the memory array non-reset, re-initialised by CLEAR only.
REQ-032 On reset mid-CLEAR or mid-RUN, SHALL abort the operation and restart CLEAR from address 0 after rst_n deasserts.

Structure
REQ-033 SHALL place the FSM state enum and the default NOP_WORD constant in the shared processor package.
REQ-034 SHALL use one sub-module, imem_array, a parametrised single-write, single-read synchronous RAM; the FSM, output register and fault logic SHALL stay in the top level.

Verification
REQ-035 Reset release with DEPTH=16: busy=1 for 16 cycles and fetch_ready=0 throughout, then busy=0; a fetch to address 5 returns 32'hE1A00000.
REQ-036 Load addr 3 = 32'hE3A01016, then fetch 3: next cycle instr_valid=1, instr_out=32'hE3A01016, instr_addr=3.
REQ-037 Load and fetch of addr 7 = 32'h8A000004 in the same cycle: next cycle instr_out=32'h8A000004.
REQ-038 Fetch 2 with stall=1 held 3 cycles: output stable, fetch_ready=0; release stall with fetch 4 pending: fetch 4 is accepted and its output appears the following cycle.
REQ-039 DEPTH=12, fetch 14: instr_out=NOP_WORD and addr_fault=1; load to addr 14 leaves addrs 0..11 unchanged.
REQ-040 rst_n asserted on cycle 5 of CLEAR: outputs go to reset values immediately; CLEAR restarts and busy lasts DEPTH cycles after release.
